// File: rtl/event_fifo.sv
// Synchronous event FIFO with registered-read or first-word-fall-through output,
// threshold flags and sticky overflow/underflow error flags.
module event_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter bit FWFT       = 1'b0,
    parameter int AFULL_TH   = DEPTH - 2,
    parameter int AEMPTY_TH  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [DATA_WIDTH-1:0]    data_in,
    input  logic                     rd_en,
    input  logic                     clr_err,
    output logic [DATA_WIDTH-1:0]    data_out,
    output logic                     rd_valid,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_empty,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  rd_acc, wr_acc;

    // Handshake: a read is taken only when something is stored; a write is taken
    // when there is room, or when the same edge frees a slot through an accepted read.
    assign empty        = (level_q == '0);
    assign full         = (level_q == LW'(DEPTH));
    assign almost_empty = (level_q <= LW'(AEMPTY_TH));
    assign almost_full  = (level_q >= LW'(AFULL_TH));
    assign level        = level_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    assign rd_acc = rd_en && !empty;
    assign wr_acc = wr_en && (!full || rd_acc);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        overflow_d  = (overflow_q && !clr_err) || (wr_en && !wr_acc);
        underflow_d = (underflow_q && !clr_err) || (rd_en && empty);
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({wr_acc, rd_acc})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately not reset; level and pointers define what is valid.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    if (FWFT) begin : g_fwft
        assign data_out = mem_q[rd_ptr_q];
        assign rd_valid = !empty;
    end else begin : g_reg
        logic [DATA_WIDTH-1:0] dout_q;
        logic                  rvalid_q;

        // On a full FIFO with read+write, the write lands in the head slot; the
        // old head is still captured here because both updates use pre-edge values.
        always_ff @(posedge clk) begin
            if (rst) begin
                dout_q   <= '0;
                rvalid_q <= 1'b0;
            end else begin
                rvalid_q <= rd_acc;
                if (rd_acc) begin
                    dout_q <= mem_q[rd_ptr_q];
                end
            end
        end

        assign data_out = dout_q;
        assign rd_valid = rvalid_q;
    end

endmodule

// File: tb/tb_event_fifo.sv
// Bench for event_fifo: one registered-read and one FWFT instance share stimulus
// and are compared against a queue-based reference model plus directed vectors.
module tb_event_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0, rd_en = 1'b0, clr_err = 1'b0;
    logic [DW-1:0] data_in = '0;

    logic [DW-1:0] dout0, dout1;
    logic          rv0, rv1, emp0, emp1, ful0, ful1, ae0, ae1, af0, af1;
    logic [LW-1:0] lvl0, lvl1;
    logic          ovf0, ovf1, unf0, unf1;

    event_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1'b0)) dut0 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .clr_err(clr_err), .data_out(dout0), .rd_valid(rv0), .empty(emp0), .full(ful0),
        .almost_empty(ae0), .almost_full(af0), .level(lvl0), .overflow(ovf0),
        .underflow(unf0)
    );

    event_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1'b1)) dut1 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .clr_err(clr_err), .data_out(dout1), .rd_valid(rv1), .empty(emp1), .full(ful1),
        .almost_empty(ae1), .almost_full(af1), .level(lvl1), .overflow(ovf1),
        .underflow(unf1)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: a plain queue of stored entries plus the visible registers.
    logic [DW-1:0] exp_q[$];
    bit            m_ovf, m_unf, m_rv0;
    logic [DW-1:0] m_dout0;

    typedef struct {
        bit            wr;
        logic [DW-1:0] din;
        bit            rd;
        bit            clr;
        int            lvl;
        logic [DW-1:0] dout;
        bit            rv;
        bit            unf;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic model_update(input bit wr, input logic [DW-1:0] din, input bit rd,
                                input bit clr);
        int  n  = exp_q.size();
        bit  ra = rd && (n != 0);
        bit  wa = wr && ((n != DEPTH) || ra);
        m_ovf = (m_ovf && !clr) || (wr && !wa);
        m_unf = (m_unf && !clr) || (rd && (n == 0));
        if (ra) begin
            m_dout0 = exp_q.pop_front();
            m_rv0   = 1'b1;
        end else begin
            m_rv0 = 1'b0;
        end
        if (wa) exp_q.push_back(din);
    endtask

    task automatic check_model();
        int n = exp_q.size();
        chk("d0.level", 32'(lvl0), 32'(n));
        chk("d1.level", 32'(lvl1), 32'(n));
        chk("d0.empty", 32'(emp0), 32'(n == 0));
        chk("d1.empty", 32'(emp1), 32'(n == 0));
        chk("d0.full", 32'(ful0), 32'(n == DEPTH));
        chk("d1.full", 32'(ful1), 32'(n == DEPTH));
        chk("d0.almost_empty", 32'(ae0), 32'(n <= 2));
        chk("d0.almost_full", 32'(af0), 32'(n >= DEPTH - 2));
        chk("d1.almost_empty", 32'(ae1), 32'(n <= 2));
        chk("d1.almost_full", 32'(af1), 32'(n >= DEPTH - 2));
        chk("d0.overflow", 32'(ovf0), 32'(m_ovf));
        chk("d0.underflow", 32'(unf0), 32'(m_unf));
        chk("d1.overflow", 32'(ovf1), 32'(m_ovf));
        chk("d1.underflow", 32'(unf1), 32'(m_unf));
        chk("d0.rd_valid", 32'(rv0), 32'(m_rv0));
        chk("d0.data_out", 32'(dout0), 32'(m_dout0));
        chk("d1.rd_valid", 32'(rv1), 32'(n != 0));
        if (n != 0) chk("d1.data_out", 32'(dout1), 32'(exp_q[0]));
    endtask

    task automatic step(input bit wr, input logic [DW-1:0] din, input bit rd, input bit clr);
        wr_en   = wr;
        data_in = din;
        rd_en   = rd;
        clr_err = clr;
        @(posedge clk);
        model_update(wr, din, rd, clr);
        #1;
        check_model();
    endtask

    // Reset with live write/read/clear requests to confirm reset wins.
    task automatic do_reset(input bit wr);
        rst     = 1'b1;
        wr_en   = wr;
        data_in = 8'hEE;
        rd_en   = wr;
        clr_err = wr;
        @(posedge clk);
        exp_q.delete();
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        m_rv0   = 1'b0;
        m_dout0 = '0;
        #1;
        rst = 1'b0;
        check_model();
    endtask

    initial begin
        bit            filling;
        int            trips;
        bit            w, r;
        logic [DW-1:0] last;

        // wr din rd clr | level dout0 rv0 underflow
        tbl[0] = '{1, 8'h11, 0, 0, 1, 8'h00, 0, 0};
        tbl[1] = '{1, 8'h22, 0, 0, 2, 8'h00, 0, 0};
        tbl[2] = '{0, 8'h00, 1, 0, 1, 8'h11, 1, 0};
        tbl[3] = '{1, 8'h33, 1, 0, 1, 8'h22, 1, 0};
        tbl[4] = '{0, 8'h00, 0, 0, 1, 8'h22, 0, 0};
        tbl[5] = '{0, 8'h00, 1, 0, 0, 8'h33, 1, 0};
        tbl[6] = '{0, 8'h00, 1, 0, 0, 8'h33, 0, 1};
        tbl[7] = '{0, 8'h00, 0, 1, 0, 8'h33, 0, 0};
        tbl[8] = '{0, 8'h00, 1, 1, 0, 8'h33, 0, 1};
        tbl[9] = '{0, 8'h00, 0, 1, 0, 8'h33, 0, 0};

        do_reset(1'b0);
        chk("reset empty", 32'(emp0), 32'd1);
        chk("reset almost_empty", 32'(ae0), 32'd1);

        foreach (tbl[i]) begin
            step(tbl[i].wr, tbl[i].din, tbl[i].rd, tbl[i].clr);
            chk($sformatf("vec%0d level", i), 32'(lvl0), 32'(tbl[i].lvl));
            chk($sformatf("vec%0d data_out", i), 32'(dout0), 32'(tbl[i].dout));
            chk($sformatf("vec%0d rd_valid", i), 32'(rv0), 32'(tbl[i].rv));
            chk($sformatf("vec%0d underflow", i), 32'(unf0), 32'(tbl[i].unf));
        end

        // Fill 0x01..0x10, then drain in order.
        do_reset(1'b0);
        for (int i = 1; i <= DEPTH; i++) begin
            step(1'b1, DW'(i), 1'b0, 1'b0);
            if (i == 13) chk("af at 13", 32'(af0), 32'd0);
            if (i == 14) chk("af at 14", 32'(af0), 32'd1);
        end
        chk("full after fill", 32'(ful0), 32'd1);
        chk("level after fill", 32'(lvl0), 32'(DEPTH));
        for (int i = 1; i <= DEPTH; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            chk("drain order", 32'(dout0), 32'(i));
            chk("drain rd_valid", 32'(rv0), 32'd1);
        end
        step(1'b0, '0, 1'b0, 1'b0);
        chk("rd_valid drops", 32'(rv0), 32'd0);
        chk("empty after drain", 32'(emp0), 32'd1);

        // Overflow on full, then simultaneous read+write on full.
        for (int i = 1; i <= DEPTH; i++) step(1'b1, DW'(i), 1'b0, 1'b0);
        step(1'b1, 8'hAA, 1'b0, 1'b0);
        chk("overflow set", 32'(ovf0), 32'd1);
        chk("level after drop", 32'(lvl0), 32'(DEPTH));
        step(1'b1, 8'hBB, 1'b1, 1'b0);
        chk("level rd+wr full", 32'(lvl0), 32'(DEPTH));
        chk("head on rd+wr", 32'(dout0), 32'h01);
        last = '0;
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            last = dout0;
        end
        chk("0xBB read last", 32'(last), 32'hBB);
        step(1'b0, '0, 1'b0, 1'b1);
        chk("overflow cleared", 32'(ovf0), 32'd0);

        // FWFT fall-through into an empty FIFO.
        do_reset(1'b0);
        step(1'b1, 8'h5A, 1'b0, 1'b0);
        chk("fwft data_out", 32'(dout1), 32'h5A);
        chk("fwft rd_valid", 32'(rv1), 32'd1);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("fwft empty after pop", 32'(emp1), 32'd1);
        chk("fwft rd_valid after pop", 32'(rv1), 32'd0);

        // Wrap: level swings between 0 and DEPTH repeatedly without errors.
        do_reset(1'b0);
        filling = 1'b1;
        trips   = 0;
        for (int c = 0; c < 600 && trips < 4; c++) begin
            w = filling ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 2);
            r = filling ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 8);
            if (exp_q.size() == 0) r = 1'b0;
            if (exp_q.size() == DEPTH && !r) w = 1'b0;
            step(w, DW'($urandom_range(0, 255)), r, 1'b0);
            if (filling && exp_q.size() == DEPTH) begin
                filling = 1'b0;
                trips++;
            end else if (!filling && exp_q.size() == 0) begin
                filling = 1'b1;
                trips++;
            end
        end
        chk("wrap trips", 32'(trips), 32'd4);
        chk("wrap no overflow", 32'(ovf0 | ovf1), 32'd0);
        chk("wrap no underflow", 32'(unf0 | unf1), 32'd0);

        // Unconstrained random traffic including errors and clears.
        do_reset(1'b0);
        for (int c = 0; c < 400; c++) begin
            step($urandom_range(0, 1) == 1, DW'($urandom_range(0, 255)),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0);
        end

        // Reset mid-transfer discards contents.
        do_reset(1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, DW'(8'h40 + i), 1'b0, 1'b0);
        step(1'b1, 8'h77, 1'b1, 1'b0);
        do_reset(1'b1);
        chk("rst level", 32'(lvl0), 32'd0);
        chk("rst empty", 32'(emp0), 32'd1);
        chk("rst flags", 32'({ovf0, unf0, ful0, af0}), 32'd0);
        step(1'b1, 8'h33, 1'b0, 1'b0);
        chk("post-rst fwft head", 32'(dout1), 32'h33);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("post-rst read", 32'(dout0), 32'h33);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
